// File: rtl/isqrt_bisect_unit_if.sv
// Request/response bundle for the bisection square-root engine.
// The requester drives the master side and the engine sits on the slave side.
interface isqrt_bisect_unit_if #(
  parameter int W = 32
);
  logic           START;
  logic [W-1:0]   N;
  logic           ROUND;
  logic           BUSY;
  logic           DONE;
  logic [W/2:0]   ROOT;
  logic [W/2:0]   REM;

  modport master (
    output START, N, ROUND,
    input  BUSY, DONE, ROOT, REM
  );

  modport slave (
    input  START, N, ROUND,
    output BUSY, DONE, ROOT, REM
  );
endinterface

// File: rtl/isqrt_bisect_unit.sv
// Integer square root by bisection on [lo, hi): one halving per cycle, W/2 steps,
// then a finish cycle that forms the floor remainder and applies optional rounding.
module isqrt_bisect_unit #(
  parameter int W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  isqrt_bisect_unit_if.slave   bus
);
  localparam int HW    = W / 2;
  localparam int RW    = HW + 1;
  localparam int ITERS = HW;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ITER   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  ncap_q, ncap_d;
  logic          round_q, round_d;
  logic [RW-1:0] lo_q, lo_d;
  logic [RW-1:0] hi_q, hi_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [RW-1:0] root_q, root_d;
  logic [RW-1:0] rem_q, rem_d;

  logic [RW-1:0]     mid;
  logic [2*RW-1:0]   mid_sq;
  logic [W-1:0]      lo_sq;
  logic [RW-1:0]     rem_fl;

  function automatic logic [RW-1:0] round_root(input logic [RW-1:0] r,
                                               input logic [RW-1:0] rem,
                                               input logic          nearest);
    // rem > r exactly when N lies past (r + 0.5)^2 = r^2 + r + 0.25
    if (nearest && (rem > r)) return r + RW'(1);
    return r;
  endfunction

  // Bisection probe: mid squared at full width so hi = 2^(W/2) never wraps
  assign mid    = RW'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
  assign mid_sq = (2*RW)'(mid) * (2*RW)'(mid);

  // Finish: lo is the floor root, so lo^2 fits in W bits and the remainder in RW bits
  assign lo_sq  = W'(lo_q) * W'(lo_q);
  assign rem_fl = RW'(ncap_q - lo_sq);

  always_comb begin
    state_d = state_q;
    ncap_d  = ncap_q;
    round_d = round_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          ncap_d  = bus.N;
          round_d = bus.ROUND;
          lo_d    = '0;
          hi_d    = RW'(1) << HW;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (mid_sq <= (2*RW)'(ncap_q)) lo_d = mid;
        else                           hi_d = mid;
        count_d = count_q + CW'(1);
        if (count_q == CW'(ITERS - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        root_d  = round_root(lo_q, rem_fl, round_q);
        rem_d   = rem_fl;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ncap_q  <= '0;
      round_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ncap_q  <= ncap_d;
      round_q <= round_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.ROOT = root_q;
  assign bus.REM  = rem_q;
endmodule
